load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 32, number of 32-bit words in the attached data memory.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req_valid input 1 and req_ready output 1  request handshake.
REQ-005 SHALL have port req_we  input  1  1=store, 0=load.
REQ-006 SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 SHALL have port req_signed  input  1  sign-extend sub-word loads.
REQ-008 SHALL have ports req_addr input 32 (byte address) and req_wdata input 32 (store data, low-aligned).
REQ-009 SHALL have ports resp_valid output 1 and resp_ready input 1  response handshake.
REQ-010 SHALL have ports resp_rdata output 32 (load result) and resp_err output 1 (request rejected).
REQ-011 SHALL have ports mem_read output 1, mem_write output 1, read_address output 32, write_address output 32, write_data output 32, read_data input 32  memory side; addresses are word indices.

Function
REQ-012 SHALL implement states IDLE, RD, RMW_RD, RMW_WR, WR, RESP; all memory-side outputs registered, decoded from state only.
REQ-013 SHALL assert req_ready only in IDLE; a request is accepted on a rising edge with req_valid=1 in IDLE, latching all req_* fields.
REQ-014 SHALL flag error when req_size=11, halfword with addr[0]=1, word with addr[1:0]!=0, or addr[31:2] >= MEM_WORDS; an erroring request goes IDLE->RESP with resp_err=1, resp_rdata=0, no memory strobe.
REQ-015 SHALL route a legal load IDLE->RD->RESP: in RD, mem_read=1, read_address=addr[31:2]; read_data captured on the rising edge ending RD.
REQ-016 SHALL route a legal word store IDLE->WR->RESP: in WR, mem_write=1, write_address=addr[31:2], write_data=req_wdata.
REQ-017 SHALL route a legal byte/halfword store IDLE->RMW_RD->RMW_WR->RESP: read word as in RD, then write it back with only the addressed lane(s) replaced.
REQ-018 SHALL use little-endian lanes: byte lane addr[1:0] (bits 8*lane+7:8*lane), halfword lane addr[1] (bits 16*addr[1]+15:16*addr[1]).
REQ-019 SHALL extract load lanes to resp_rdata bit 0, zero-extended when req_signed=0, sign-extended when req_signed=1; word loads ignore req_signed.
REQ-020 SHALL never assert mem_read and mem_write in the same cycle; both 0 outside RD/RMW_RD/WR/RMW_WR.
REQ-021 SHALL hold resp_valid=1 and resp_rdata/resp_err stable in RESP until resp_ready=1 at a rising edge, then return to IDLE; stores return resp_rdata=0.
REQ-022 SHALL give latency, accept edge to resp_valid: 2 cycles load/word store, 3 cycles sub-word store, 1 cycle error.
REQ-023 SHALL not accept a new request in the cycle the response is consumed (one idle cycle minimum between transactions).

Reset
REQ-024 SHALL, while rst=0, asynchronously force IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, all address/data outputs 0.
REQ-025 SHALL abandon any in-flight transaction on reset, including mid-RMW; no response is produced for it.

Verification
REQ-026 SHALL pass: memory reset to word i = i; load word addr 0x14 -> resp_rdata=0x00000005, resp_err=0, resp_valid 2 cycles after accept.
REQ-027 SHALL pass: store word 0xDEADBEEF at 0x08, then signed byte load at 0x0B -> 0xFFFFFFDE; unsigned halfword load at 0x08 -> 0x0000BEEF.
REQ-028 SHALL pass: word 3 = 0x11223344, byte store 0xAA at 0x0D -> word 3 = 0x1122AA44, mem_read then mem_write in consecutive cycles, resp 3 cycles after accept.
REQ-029 SHALL pass: word load at 0x06, halfword at 0x03, size 11, address 0x80 -> each resp_err=1 after 1 cycle, mem_read=mem_write=0 throughout.
REQ-030 SHALL pass: resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0; resp_ready=1 -> IDLE next edge.
REQ-031 SHALL pass: rst driven 0 during RMW_WR -> mem_write drops immediately, IDLE, resp_valid=0; no response after rst returns to 1.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between a request/response port and a word-organised data memory.
// Sub-word stores use read-modify-write; misaligned or out-of-range requests answer with an error.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] read_address,
  output logic [31:0] write_address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, RMW_WR, WR, RESP} state_t;

  state_t state, state_nxt;

  logic [1:0]  size_q;
  logic        sgn_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        accept;
  logic        req_err;
  logic [31:0] cur_addr;
  logic [31:0] word_idx;
  logic        mem_read_d, mem_write_d;
  logic [31:0] read_address_d, write_address_d, write_data_d;
  logic [31:0] resp_rdata_d;
  logic        resp_err_d;

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] size,
                                               input logic sgn, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   load_extract = {{24{sgn & b[7]}}, b};
      2'b01:   load_extract = {{16{sgn & h[15]}}, h};
      default: load_extract = w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] wd,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] m;
    m = w;
    if (size == 2'b00) m[{lane, 3'b000} +: 8] = wd[7:0];
    else               m[{lane[1], 4'b0000} +: 16] = wd[15:0];
    return m;
  endfunction

  assign accept  = (state == IDLE) && req_valid;
  assign req_err = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                   ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      read_address  <= '0;
      write_address <= '0;
      write_data    <= '0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
    end else begin
      state         <= state_nxt;
      mem_read      <= mem_read_d;
      mem_write     <= mem_write_d;
      read_address  <= read_address_d;
      write_address <= write_address_d;
      write_data    <= write_data_d;
      resp_rdata    <= resp_rdata_d;
      resp_err      <= resp_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      size_q  <= '0;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      size_q  <= req_size;
      sgn_q   <= req_signed;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) begin
        if (req_err)              state_nxt = RESP;
        else if (!req_we)         state_nxt = RD;
        else if (req_size == 2'b10) state_nxt = WR;
        else                      state_nxt = RMW_RD;
      end
      RD:      state_nxt = RESP;
      WR:      state_nxt = RESP;
      RMW_RD:  state_nxt = RMW_WR;
      RMW_WR:  state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory strobes are decoded from the next state so the registered copies line up with the state.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);

    cur_addr        = (state == IDLE) ? req_addr : addr_q;
    word_idx        = {2'b00, cur_addr[31:2]};
    mem_read_d      = (state_nxt == RD) || (state_nxt == RMW_RD);
    mem_write_d     = (state_nxt == WR) || (state_nxt == RMW_WR);
    read_address_d  = mem_read_d  ? word_idx : '0;
    write_address_d = mem_write_d ? word_idx : '0;
    write_data_d    = '0;
    if (state_nxt == WR)     write_data_d = req_wdata;
    if (state_nxt == RMW_WR) write_data_d = store_merge(read_data, wdata_q, size_q, addr_q[1:0]);

    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    case (state)
      IDLE: resp_err_d   = accept && req_err;
      RD:   resp_rdata_d = load_extract(read_data, size_q, sgn_q, addr_q[1:0]);
      RESP: if (!resp_ready) begin
        resp_rdata_d = resp_rdata;
        resp_err_d   = resp_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboarded bench for load_store_unit with a 32-word memory model initialised to word i = i.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [31:0] read_address, write_address, write_data, read_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [7:0]  pat;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] mem     [0:31];
  logic [31:0] ref_mem [0:31];
  logic        mem_loaded = 1'b0;

  load_store_unit #(.MEM_WORDS(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write),
    .read_address(read_address), .write_address(write_address),
    .write_data(write_data), .read_data(read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'(i);
      mem_loaded <= 1'b1;
    end else if (mem_write && write_address < 32) begin
      mem[write_address[4:0]] <= write_data;
    end
  end

  assign read_data = (mem_read && read_address < 32) ? mem[read_address[4:0]] : 32'hA5A5A5A5;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (rst) check("rw_excl", 32'(mem_read & mem_write), 32'd0);

  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
    logic [31:0] w, v, mask;
    int sh;
    e.err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
            (size == 2'd2 && addr[1:0] != 2'd0) || (addr >= 32'd128);
    e.rdata = 32'd0;
    if (e.err) begin
      e.lat = 1; e.pat = 8'b0000_0000;
      return;
    end
    w = ref_mem[addr[6:2]];
    if (!we) begin
      e.lat = 2; e.pat = 8'b0000_1000;
      if (size == 2'd0) begin
        sh = 8 * int'(addr[1:0]);
        v = (w >> sh) & 32'hFF;
        if (sgn && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size == 2'd1) begin
        sh = 16 * int'(addr[1]);
        v = (w >> sh) & 32'hFFFF;
        if (sgn && v[15]) v = v | 32'hFFFF_0000;
      end else begin
        v = w;
      end
      e.rdata = v;
    end else if (size == 2'd2) begin
      e.lat = 2; e.pat = 8'b0000_0100;
      ref_mem[addr[6:2]] = wdata;
    end else begin
      e.lat = 3; e.pat = 8'b0010_0100;
      sh   = (size == 2'd0) ? 8 * int'(addr[1:0]) : 16 * int'(addr[1]);
      mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
      ref_mem[addr[6:2]] = (w & ~mask) | ((wdata << sh) & mask);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    exp_t e, got;
    int lat;
    logic [7:0] pat;
    logic seen;
    model(we, size, sgn, addr, wdata, e);
    exp_q.push_back(e);
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; pat = 8'd0; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      lat++;
      pat = {pat[5:0], mem_read, mem_write};
      if (resp_valid) seen = 1'b1;
    end
    check("resp_timeout", 32'(seen), 32'd1);
    got = exp_q.pop_front();
    check("latency", 32'(lat), 32'(got.lat));
    check("resp_err", 32'(resp_err), 32'(got.err));
    check("resp_rdata", resp_rdata, got.rdata);
    check("strobe_seq", 32'(pat), 32'(got.pat));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, got.rdata);
      check("hold_err", 32'(resp_err), 32'(got.err));
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check("post_valid", 32'(resp_valid), 32'd0);
    check("post_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic        r_we, r_sgn, seen_wr;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata;

    for (int i = 0; i < 32; i++) ref_mem[i] = 32'(i);
    rst = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_read_addr", read_address, 32'd0);
    check("rst_write_addr", write_address, 32'd0);
    check("rst_write_data", write_data, 32'd0);
    rst = 1'b1;

    do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 0);
    do_req(1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF, 0);
    do_req(1'b0, 2'd0, 1'b1, 32'h0B, 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'h08, 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b1, 32'h0A, 32'h0, 0);
    do_req(1'b1, 2'd2, 1'b0, 32'h0C, 32'h11223344, 0);
    do_req(1'b1, 2'd0, 1'b0, 32'h0D, 32'h000000AA, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 0);
    do_req(1'b0, 2'd1, 1'b0, 32'h03, 32'h0, 0);
    do_req(1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 0);
    do_req(1'b1, 2'd1, 1'b0, 32'h7E, 32'h0000CAFE, 0);
    do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000F00D, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5);
    do_req(1'b0, 2'd0, 1'b0, 32'h7F, 32'h0, 0);

    for (int k = 0; k < 24; k++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_size  = 2'($urandom_range(0, 3));
      r_sgn   = 1'($urandom_range(0, 1));
      r_addr  = 32'($urandom_range(0, 143));
      r_wdata = $urandom;
      do_req(r_we, r_size, r_sgn, r_addr, r_wdata, int'($urandom_range(0, 2)));
    end

    // byte store aborted by reset while writing back
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen_wr = 1'b0;
    for (int i = 0; i < 6 && !seen_wr; i++) begin
      @(negedge clk);
      if (mem_write) seen_wr = 1'b1;
    end
    check("rmw_wr_reached", 32'(seen_wr), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_mem_write", 32'(mem_write), 32'd0);
    check("abort_mem_read", 32'(mem_read), 32'd0);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_resp", 32'(resp_valid), 32'd0);
    end

    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0);

    for (int i = 0; i < 32; i++) check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
